cache_mem_arbiter: RTL and testbench

- Memory-side responder for the cache request protocol: services dcache (dREN/dWEN/daddr/dstore) and icache (iREN/iaddr) requests.
- Returns dwait/iwait and dload/iload to each cache.
- Drives a single-port RAM (ramREN/ramWEN/ramaddr/ramstore) and consumes ramstate/ramload.
- Sits between the two L1 caches and main memory. Data requests have priority, with a bounded anti-starvation rule for instruction fetch.

---
 rtl/cpu_types_pkg.sv | 4 +
 rtl/diaosi_types_pkg.sv | 17 +
 rtl/cache_mem_arbiter_if.sv | 34 +++
 rtl/cache_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Basic CPU-wide data types shared by the cache and memory blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// Shared types for the memory arbiter: FSM states, RAM status codes and the default burst limit.
package diaosi_types_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_D    = 2'd1,
    ARB_I    = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int DEF_MAX_DBURST = 4;
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory bus: dcache and icache request channels plus the single-port RAM channel.
interface cache_mem_arbiter_if;
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

  // Handshake: a cache holds its REN/WEN, address and data stable until its
  // wait is 0 for one cycle; that cycle is the transfer, and load is valid only then.
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Arbitrates dcache/icache word requests onto one RAM port, dcache first with bounded icache starvation.
// Optional grant counters are enabled with the ARB_STATS_EN macro.
module cache_mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int MAX_DBURST = DEF_MAX_DBURST
) (
  input  logic                CLK,
  input  logic                nRST,
  cache_mem_arbiter_if.slave  bus,
  output logic                ram_err,
`ifdef ARB_STATS_EN
  output word_t               dgrant_cnt,
  output word_t               igrant_cnt,
`endif
  output arb_state_t          dbg_state
);

  localparam int BW = $clog2(MAX_DBURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DBURST);

  arb_state_t    state, next_state;
  logic [BW-1:0] burst;
  logic          d_done, i_done, grant_active;

  assign dbg_state = state;

  always_comb begin
    next_state   = state;
    d_done       = 1'b0;
    i_done       = 1'b0;
    grant_active = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    case (state)
      ARB_IDLE: begin
        if ((bus.dREN || bus.dWEN) && !(bus.iREN && burst == BURST_MAX))
          next_state = ARB_D;
        else if (bus.iREN)
          next_state = ARB_I;
      end
      ARB_D: begin
        if (bus.dREN || bus.dWEN) begin
          grant_active = 1'b1;
          bus.ramaddr  = bus.daddr;
          // A write takes precedence over a simultaneous read.
          if (bus.dWEN) begin
            bus.ramWEN   = 1'b1;
            bus.ramstore = bus.dstore;
          end else begin
            bus.ramREN   = 1'b1;
          end
          if (bus.ramstate == ACCESS) begin
            bus.dwait  = 1'b0;
            bus.dload  = bus.dWEN ? '0 : bus.ramload;
            d_done     = 1'b1;
            next_state = ARB_IDLE;
          end
        end else begin
          next_state = ARB_IDLE;
        end
      end
      ARB_I: begin
        if (bus.iREN) begin
          grant_active = 1'b1;
          bus.ramREN   = 1'b1;
          bus.ramaddr  = bus.iaddr;
          if (bus.ramstate == ACCESS) begin
            bus.iwait  = 1'b0;
            bus.iload  = bus.ramload;
            i_done     = 1'b1;
            next_state = ARB_IDLE;
          end
        end else begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ARB_IDLE;
      burst   <= '0;
      ram_err <= 1'b0;
    end else begin
      state <= next_state;
      // Burst counts dcache words completed while icache is waiting; saturates at the limit.
      if (d_done) begin
        if (!bus.iREN)
          burst <= '0;
        else if (burst != BURST_MAX)
          burst <= burst + 1'b1;
      end else if (i_done) begin
        burst <= '0;
      end
      if (grant_active && bus.ramstate == ERROR)
        ram_err <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dgrant_cnt <= '0;
      igrant_cnt <= '0;
    end else begin
      if (d_done) dgrant_cnt <= dgrant_cnt + 32'd1;
      if (i_done) igrant_cnt <= igrant_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: the bench plays both caches and the RAM status/data.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       ram_err;
  arb_state_t dbg_state;
`ifdef ARB_STATS_EN
  word_t      dgrant_cnt;
  word_t      igrant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.MAX_DBURST(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus.slave),
    .ram_err   (ram_err),
`ifdef ARB_STATS_EN
    .dgrant_cnt(dgrant_cnt),
    .igrant_cnt(igrant_cnt),
`endif
    .dbg_state (dbg_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         n_d;
    int         n_i;
    int         n_done;
    logic [6:0] got_i;
    logic [6:0] exp_i;

    nRST         = 1'b1;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
    #2 nRST = 1'b0;
    #1;
    chk("rst_dwait",   32'(bus.dwait),   32'd1);
    chk("rst_iwait",   32'(bus.iwait),   32'd1);
    chk("rst_ramREN",  32'(bus.ramREN),  32'd0);
    chk("rst_ramWEN",  32'(bus.ramWEN),  32'd0);
    chk("rst_ramaddr", bus.ramaddr,      32'd0);
    chk("rst_dload",   bus.dload,        32'd0);
    chk("rst_ram_err", 32'(ram_err),     32'd0);
    chk("rst_state",   32'(dbg_state),   32'(ARB_IDLE));
    tick();
    nRST = 1'b1;

    // 1: dcache read, RAM answers ACCESS two cycles after the strobe.
    tick();
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    #1 chk("t1_idle_noren", 32'(bus.ramREN), 32'd0);
    tick();
    #1 chk("t1_ramREN",   32'(bus.ramREN), 32'd1);
    chk("t1_ramaddr",     bus.ramaddr,     32'h40);
    chk("t1_dwait_free",  32'(bus.dwait),  32'd1);
    tick();
    bus.ramstate = BUSY;
    #1 chk("t1_dwait_busy", 32'(bus.dwait), 32'd1);
    chk("t1_dload_busy",    bus.dload,      32'd0);
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    #1 chk("t1_dwait", 32'(bus.dwait), 32'd0);
    chk("t1_dload",    bus.dload,      32'hDEADBEEF);
    chk("t1_iwait",    32'(bus.iwait), 32'd1);
    chk("t1_iload",    bus.iload,      32'd0);
    tick();
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    #1 chk("t1_back_idle", 32'(dbg_state), 32'(ARB_IDLE));
    chk("t1_dwait_after",  32'(bus.dwait), 32'd1);

    // 2: dcache write with icache pending; write first, then the fetch.
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'h12345678;
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h100;
    tick();
    #1 chk("t2_ramWEN", 32'(bus.ramWEN), 32'd1);
    chk("t2_ramREN",    32'(bus.ramREN), 32'd0);
    chk("t2_ramaddr",   bus.ramaddr,     32'h80);
    chk("t2_ramstore",  bus.ramstore,    32'h12345678);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hAAAA5555;
    #1 chk("t2_dwait", 32'(bus.dwait), 32'd0);
    chk("t2_dload_wr", bus.dload,      32'd0);
    chk("t2_iwait",    32'(bus.iwait), 32'd1);
    tick();
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    #1 chk("t2_idle", 32'(dbg_state), 32'(ARB_IDLE));
    tick();
    #1 chk("t2_i_grant", 32'(dbg_state), 32'(ARB_I));
    chk("t2_i_addr",     bus.ramaddr,    32'h100);
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h11112222;
    #1 chk("t2_iwait0", 32'(bus.iwait), 32'd0);
    chk("t2_iload",     bus.iload,      32'h11112222);
    chk("t2_dwait1",    32'(bus.dwait), 32'd1);
    tick();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;

    // 3: six dcache reads with icache held; the fifth completion is forced to icache.
    n_d    = 0;
    n_i    = 0;
    n_done = 0;
    got_i  = '0;
    exp_i  = 7'b0010000;
    bus.ramstate = ACCESS;
    bus.dREN     = 1'b1;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h300;
    for (int c = 0; c < 40 && n_done < 7; c++) begin
      if (c > 0) tick();
      if (n_i >= 1) bus.iREN = 1'b0;
      if (n_d >= 6) bus.dREN = 1'b0;
      bus.daddr   = 32'h400 + 32'(4 * n_d);
      bus.ramload = 32'h1000 + 32'(c);
      #1;
      if (!bus.dwait) begin
        n_d++;
        n_done++;
      end
      if (!bus.iwait) begin
        chk("t3_iload",   bus.iload,   32'h1000 + 32'(c));
        chk("t3_iramadr", bus.ramaddr, 32'h300);
        got_i[n_done] = 1'b1;
        n_i++;
        n_done++;
      end
    end
    chk("t3_done_cnt", 32'(n_done), 32'd7);
    chk("t3_order",    32'(got_i),  32'(exp_i));
    tick();
    bus.dREN     = 1'b0;
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    #1 chk("t3_idle", 32'(dbg_state), 32'(ARB_IDLE));

    // 4: dcache withdraws its request before ACCESS.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h44;
    tick();
    #1 chk("t4_ramREN", 32'(bus.ramREN), 32'd1);
    tick();
    bus.dREN = 1'b0;
    #1 chk("t4_ramREN_drop", 32'(bus.ramREN), 32'd0);
    chk("t4_no_dwait",       32'(bus.dwait),  32'd1);
    tick();
    #1 chk("t4_idle", 32'(dbg_state), 32'(ARB_IDLE));

    // 5: RAM reports ERROR for three cycles during an icache grant.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h200;
    tick();
    bus.ramstate = ERROR;
    #1 chk("t5_iwait_err", 32'(bus.iwait), 32'd1);
    chk("t5_err_not_yet",  32'(ram_err),   32'd0);
    tick();
    #1 chk("t5_err_set", 32'(ram_err), 32'd1);
    tick();
    #1 chk("t5_iwait_err3", 32'(bus.iwait), 32'd1);
    tick();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hCAFEF00D;
    #1 chk("t5_iwait0", 32'(bus.iwait), 32'd0);
    chk("t5_iload",     bus.iload,      32'hCAFEF00D);
    tick();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    #1 chk("t5_err_sticky", 32'(ram_err), 32'd1);
    chk("t5_iload_idle",    bus.iload,    32'd0);

`ifdef ARB_STATS_EN
    chk("stats_d", dgrant_cnt, 32'd8);
    chk("stats_i", igrant_cnt, 32'd3);
`endif

    // 6: reset asserted in the middle of a dcache grant.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h48;
    tick();
    bus.ramstate = BUSY;
    #1 chk("t6_in_d", 32'(dbg_state), 32'(ARB_D));
    nRST = 1'b0;
    #1 chk("t6_dwait", 32'(bus.dwait),  32'd1);
    chk("t6_iwait",    32'(bus.iwait),  32'd1);
    chk("t6_ramREN",   32'(bus.ramREN), 32'd0);
    chk("t6_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("t6_ramaddr",  bus.ramaddr,     32'd0);
    chk("t6_ram_err",  32'(ram_err),    32'd0);
    chk("t6_state",    32'(dbg_state),  32'(ARB_IDLE));
`ifdef ARB_STATS_EN
    chk("t6_stats_d", dgrant_cnt, 32'd0);
    chk("t6_stats_i", igrant_cnt, 32'd0);
`endif
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    tick();
    nRST = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
